// File: rtl/lcd_clock_bcd.sv
// HH:MM:SS BCD real-time clock advanced by a sampled 2 Hz strobe, with load,
// pause, colon-blink and LCD refresh pulses. Single clock domain.
module lcd_clock_bcd #(
  parameter int unsigned EDGES_PER_SEC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       q2hz,
  input  logic       en,
  input  logic       load,
  input  logic [7:0] ld_hh,
  input  logic [7:0] ld_mm,
  input  logic [7:0] ld_ss,
  output logic [3:0] hh_t,
  output logic [3:0] hh_u,
  output logic [3:0] mm_t,
  output logic [3:0] mm_u,
  output logic [3:0] ss_t,
  output logic [3:0] ss_u,
  output logic       colon,
  output logic       sec_tick,
  output logic       upd,
  output logic       ld_err
);

  localparam int unsigned PhaseW = (EDGES_PER_SEC > 1) ? $clog2(EDGES_PER_SEC) : 1;
  localparam logic [PhaseW-1:0] PhaseMax  = PhaseW'(EDGES_PER_SEC - 1);
  localparam logic [PhaseW-1:0] PhaseHalf = PhaseW'(EDGES_PER_SEC / 2);
  localparam logic [PhaseW-1:0] PhaseOne  = PhaseW'(1);

  // Time packed as {hh_t, hh_u, mm_t, mm_u, ss_t, ss_u}.
  logic [23:0]       time_q, time_d, time_inc;
  logic [PhaseW-1:0] phase_q, phase_d;
  logic              s1_q, s2_q, s3_q;
  logic              colon_q, colon_d;
  logic              tick_q, tick_d;
  logic              upd_q, upd_d;
  logic              err_q, err_d;
  logic              q_edge;
  logic              ld_valid;
  logic              ld_ok;

  assign q_edge = s2_q & ~s3_q;

  assign ld_valid = (ld_hh <= 8'h23) && (ld_hh[3:0] <= 4'd9) &&
                    (ld_mm[7:4] <= 4'd5) && (ld_mm[3:0] <= 4'd9) &&
                    (ld_ss[7:4] <= 4'd5) && (ld_ss[3:0] <= 4'd9);

  // One-second increment with the full carry chain resolved in a single cycle.
  always_comb begin
    logic [3:0] ht, hu, mt, mu, st, su;
    logic       c0, c1, c2, c3;
    {ht, hu, mt, mu, st, su} = time_q;
    c0 = (su == 4'd9);
    c1 = c0 && (st == 4'd5);
    c2 = c1 && (mu == 4'd9);
    c3 = c2 && (mt == 4'd5);
    time_inc = time_q;
    time_inc[3:0]   = c0 ? 4'd0 : su + 4'd1;
    time_inc[7:4]   = c0 ? (c1 ? 4'd0 : st + 4'd1) : st;
    time_inc[11:8]  = c1 ? (c2 ? 4'd0 : mu + 4'd1) : mu;
    time_inc[15:12] = c2 ? (c3 ? 4'd0 : mt + 4'd1) : mt;
    if (c3) begin
      if ({ht, hu} == 8'h23) begin
        time_inc[23:16] = 8'h00;
      end else if (hu == 4'd9) begin
        time_inc[23:16] = {ht + 4'd1, 4'd0};
      end else begin
        time_inc[23:16] = {ht, hu + 4'd1};
      end
    end
  end

  always_comb begin
    time_d  = time_q;
    phase_d = phase_q;
    tick_d  = 1'b0;
    err_d   = 1'b0;
    ld_ok   = 1'b0;
    // A load, valid or not, swallows any coincident 2 Hz edge.
    if (load) begin
      if (ld_valid) begin
        time_d  = {ld_hh, ld_mm, ld_ss};
        phase_d = '0;
        ld_ok   = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else if (q_edge && en) begin
      if (phase_q == PhaseMax) begin
        phase_d = '0;
        time_d  = time_inc;
        tick_d  = 1'b1;
      end else begin
        phase_d = phase_q + PhaseOne;
      end
    end
    colon_d = !en || (EDGES_PER_SEC == 1) || (phase_d < PhaseHalf);
    upd_d   = ld_ok || (time_d != time_q) || (colon_d != colon_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      time_q  <= '0;
      phase_q <= '0;
      colon_q <= 1'b1;
      tick_q  <= 1'b0;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      s1_q    <= q2hz;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      time_q  <= time_d;
      phase_q <= phase_d;
      colon_q <= colon_d;
      tick_q  <= tick_d;
      upd_q   <= upd_d;
      err_q   <= err_d;
    end
  end

  assign {hh_t, hh_u, mm_t, mm_u, ss_t, ss_u} = time_q;
  assign colon    = colon_q;
  assign sec_tick = tick_q;
  assign upd      = upd_q;
  assign ld_err   = err_q;

endmodule

// File: tb/tb_lcd_clock_bcd.sv
// Directed bench for lcd_clock_bcd: reset, counting, rollovers, load rejection,
// pause/resume and load/reset priority, checked with immediate assertions.
module tb_lcd_clock_bcd;

  logic       clk = 1'b0;
  logic       rst, q2hz, en, load;
  logic [7:0] ld_hh, ld_mm, ld_ss;
  logic [3:0] hh_t, hh_u, mm_t, mm_u, ss_t, ss_u;
  logic       colon, sec_tick, upd, ld_err;
  logic [23:0] now;

  int vectors     = 0;
  int miscompares = 0;
  int tick_cnt    = 0;
  int base;

  lcd_clock_bcd #(.EDGES_PER_SEC(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .q2hz     (q2hz),
    .en       (en),
    .load     (load),
    .ld_hh    (ld_hh),
    .ld_mm    (ld_mm),
    .ld_ss    (ld_ss),
    .hh_t     (hh_t),
    .hh_u     (hh_u),
    .mm_t     (mm_t),
    .mm_u     (mm_u),
    .ss_t     (ss_t),
    .ss_u     (ss_u),
    .colon    (colon),
    .sec_tick (sec_tick),
    .upd      (upd),
    .ld_err   (ld_err)
  );

  always #5 clk = ~clk;

  assign now = {hh_t, hh_u, mm_t, mm_u, ss_t, ss_u};

  always @(posedge clk) if (sec_tick === 1'b1) tick_cnt <= tick_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    @(negedge clk);
    ld_hh = h; ld_mm = m; ld_ss = s; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Raise q2hz and return at the negedge after the 3rd rising clk edge.
  task automatic q_rise();
    @(negedge clk);
    q2hz = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("no_early_update", {31'b0, sec_tick | upd}, 32'd0);
    @(negedge clk);
  endtask

  task automatic q_low();
    q2hz = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; q2hz = 1'b0; en = 1'b1; load = 1'b0;
    ld_hh = 8'h00; ld_mm = 8'h00; ld_ss = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_time", {8'b0, now}, 32'h000000);
    chk("rst_colon", {31'b0, colon}, 32'd1);
    chk("rst_pulses", {29'b0, sec_tick, upd, ld_err}, 32'd0);
    repeat (6) @(negedge clk);
    chk("idle_time", {8'b0, now}, 32'h000000);
    chk("idle_ticks", tick_cnt, 32'd0);

    // Basic counting across a minute boundary.
    do_load(8'h12, 8'h34, 8'h58);
    chk("load_time", {8'b0, now}, 32'h123458);
    chk("load_upd", {31'b0, upd}, 32'd1);
    chk("load_colon", {31'b0, colon}, 32'd1);
    base = tick_cnt;
    q_rise();
    chk("r1_time", {8'b0, now}, 32'h123458);
    chk("r1_colon", {31'b0, colon}, 32'd0);
    chk("r1_pulses", {30'b0, sec_tick, upd}, 32'b01);
    q_low();
    q_rise();
    chk("r2_time", {8'b0, now}, 32'h123459);
    chk("r2_colon", {31'b0, colon}, 32'd1);
    chk("r2_pulses", {30'b0, sec_tick, upd}, 32'b11);
    q_low();
    q_rise();
    chk("r3_colon", {31'b0, colon}, 32'd0);
    q_low();
    q_rise();
    chk("r4_time", {8'b0, now}, 32'h123500);
    chk("r4_tick", {31'b0, sec_tick}, 32'd1);
    q_low();
    chk("count_ticks", tick_cnt - base, 32'd2);

    // Rollovers.
    do_load(8'h23, 8'h59, 8'h59);
    base = tick_cnt;
    q_rise(); q_low(); q_rise();
    chk("wrap_day", {8'b0, now}, 32'h000000);
    chk("wrap_tick", {31'b0, sec_tick}, 32'd1);
    q_low();
    chk("wrap_ticks", tick_cnt - base, 32'd1);
    do_load(8'h09, 8'h59, 8'h59);
    q_rise(); q_low(); q_rise(); q_low();
    chk("wrap_09", {8'b0, now}, 32'h100000);
    do_load(8'h19, 8'h59, 8'h59);
    q_rise(); q_low(); q_rise(); q_low();
    chk("wrap_19", {8'b0, now}, 32'h200000);

    // Rejected loads.
    do_load(8'h24, 8'h00, 8'h00);
    chk("bad_hh_err", {31'b0, ld_err}, 32'd1);
    chk("bad_hh_time", {8'b0, now}, 32'h200000);
    chk("bad_hh_upd", {31'b0, upd}, 32'd0);
    @(negedge clk);
    chk("err_one_cycle", {31'b0, ld_err}, 32'd0);
    do_load(8'h12, 8'h60, 8'h00);
    chk("bad_mm_err", {31'b0, ld_err}, 32'd1);
    chk("bad_mm_time", {8'b0, now}, 32'h200000);
    do_load(8'h12, 8'h3A, 8'h00);
    chk("bad_nib_err", {31'b0, ld_err}, 32'd1);
    chk("bad_nib_time", {8'b0, now}, 32'h200000);

    // Pause with the phase mid-second, then resume.
    q_rise(); q_low();
    chk("pre_pause_colon", {31'b0, colon}, 32'd0);
    base = tick_cnt;
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("pause_colon", {31'b0, colon}, 32'd1);
    chk("pause_upd", {31'b0, upd}, 32'd1);
    @(negedge clk);
    chk("pause_upd_once", {31'b0, upd}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      q_rise();
      q_low();
    end
    chk("pause_time", {8'b0, now}, 32'h200000);
    chk("pause_colon_held", {31'b0, colon}, 32'd1);
    chk("pause_ticks", tick_cnt - base, 32'd0);
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    chk("resume_colon", {31'b0, colon}, 32'd0);
    chk("resume_upd", {31'b0, upd}, 32'd1);
    q_rise();
    chk("resume_time", {8'b0, now}, 32'h200001);
    chk("resume_tick", {31'b0, sec_tick}, 32'd1);
    q_low();

    // Load coincident with an edge wins and suppresses the tick.
    base = tick_cnt;
    @(negedge clk);
    q2hz = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ld_hh = 8'h07; ld_mm = 8'h08; ld_ss = 8'h09; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("coinc_time", {8'b0, now}, 32'h070809);
    chk("coinc_pulses", {30'b0, sec_tick, upd}, 32'b01);
    q_low();
    chk("coinc_ticks", tick_cnt - base, 32'd0);
    chk("coinc_held", {8'b0, now}, 32'h070809);

    // Reset beats a simultaneous load.
    @(negedge clk);
    rst = 1'b1; load = 1'b1;
    ld_hh = 8'h11; ld_mm = 8'h11; ld_ss = 8'h11;
    @(negedge clk);
    rst = 1'b0; load = 1'b0;
    chk("rst_load_time", {8'b0, now}, 32'h000000);
    chk("rst_load_colon", {31'b0, colon}, 32'd1);
    chk("rst_load_upd", {31'b0, upd}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
